// File: rtl/pci_arbiter_n.sv
// PCI bus arbiter: fixed-priority or round-robin grant of GNT# with
// bus parking, preemption of long transactions and grant timeout.
module pci_arbiter_n #(
  parameter int NUM_MASTERS = 5,
  parameter int MODE        = 0,
  parameter int PARK_EN     = 1,
  parameter int PARK_MASTER = 0,
  parameter int GNT_TIMEOUT = 16,
  localparam int N  = NUM_MASTERS,
  localparam int OW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] requests,
  input  logic                   frame,
  input  logic                   iReady,
  output logic [NUM_MASTERS-1:0] grants,
  output logic [OW-1:0]          owner,
  output logic                   owner_valid,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY,
    SWITCH
  } state_e;

  localparam logic [OW-1:0] PARK = OW'(PARK_MASTER);
  localparam bit PARK_ON = (PARK_EN != 0);

  state_e        state_q, state_d;
  logic [N-1:0]  grants_q, grants_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          owner_valid_q, owner_valid_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic          mask_q, mask_d;

  logic [N-1:0]  req;
  logic [N-1:0]  elig;
  logic [N-1:0]  own_1h;
  logic [N-1:0]  idle_gnt;
  logic          idle_bus;
  logic          cnt_hit;
  logic [7:0]    cnt_inc;
  logic [OW-1:0] ptr_nxt;
  logic [OW-1:0] win_ptr;
  logic [OW-1:0] win_nxt;
  logic [OW-1:0] gnt_w;
  logic          go_idle;
  logic          go_grant;
  logic          go_switch;

  function automatic logic [N-1:0] gnt_of(
    input logic [OW-1:0] idx
  );
    logic [N-1:0] g;
    g = '1;
    g[idx] = 1'b0;
    return g;
  endfunction

  // Round-robin scans downward so the lowest offset from start wins.
  function automatic logic [OW-1:0] pick(
    input logic [N-1:0]  v,
    input logic [OW-1:0] start
  );
    logic [OW-1:0] w;
    int idx;
    w = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (v[OW'(i)]) w = OW'(i);
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = int'(start) + k;
        if (idx >= N) idx = idx - N;
        if (v[OW'(idx)]) w = OW'(idx);
      end
    end
    return w;
  endfunction

  always_comb begin
    req      = ~requests;
    idle_bus = frame & iReady;
    own_1h   = ~gnt_of(owner_q);
    elig     = req;
    if (mask_q) elig[owner_q] = 1'b0;
    ptr_nxt  = (owner_q == OW'(N - 1)) ?
               '0 : owner_q + OW'(1);
    win_ptr  = pick(elig, ptr_q);
    win_nxt  = pick(elig, ptr_nxt);
    cnt_inc  = (cnt_q == 8'hFF) ?
               cnt_q : cnt_q + 8'd1;
    cnt_hit  = ({1'b0, cnt_q} + 9'd1) >=
               9'(GNT_TIMEOUT);
    idle_gnt = PARK_ON ? gnt_of(PARK) : '1;
  end

  always_comb begin
    state_d       = state_q;
    grants_d      = grants_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    timeout_d     = 1'b0;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    mask_d        = 1'b0;
    go_idle       = 1'b0;
    go_grant      = 1'b0;
    go_switch     = 1'b0;
    gnt_w         = win_ptr;

    unique case (state_q)
      IDLE: begin
        if (|elig && idle_bus) begin
          if (PARK_ON && win_ptr != PARK)
            go_switch = 1'b1;
          else
            go_grant = 1'b1;
        end else begin
          go_idle = 1'b1;
        end
      end
      GRANT: begin
        if (!frame) begin
          state_d = BUSY;
        end else if (idle_bus && requests[owner_q]) begin
          go_switch = 1'b1;
          ptr_d     = ptr_nxt;
        end else if (idle_bus) begin
          cnt_d = cnt_inc;
          if (cnt_hit) begin
            go_switch = 1'b1;
            ptr_d     = ptr_nxt;
            timeout_d = 1'b1;
            mask_d    = 1'b1;
          end
        end
      end
      BUSY: begin
        if (idle_bus) begin
          ptr_d = ptr_nxt;
          if (|elig) begin
            go_grant = 1'b1;
            gnt_w    = win_nxt;
          end else begin
            go_idle = 1'b1;
          end
        end else if (|(elig & ~own_1h)) begin
          grants_d      = '1;
          owner_valid_d = 1'b0;
        end else begin
          grants_d      = gnt_of(owner_q);
          owner_valid_d = 1'b1;
        end
      end
      SWITCH: begin
        if (|elig) go_grant = 1'b1;
        else       go_idle  = 1'b1;
      end
    endcase

    if (go_switch) begin
      state_d       = SWITCH;
      grants_d      = '1;
      owner_valid_d = 1'b0;
    end
    if (go_grant) begin
      state_d       = GRANT;
      grants_d      = gnt_of(gnt_w);
      owner_d       = gnt_w;
      owner_valid_d = 1'b1;
      cnt_d         = '0;
    end
    if (go_idle) begin
      state_d       = IDLE;
      grants_d      = idle_gnt;
      owner_d       = PARK_ON ? PARK : owner_q;
      owner_valid_d = PARK_ON;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grants_q      <= '1;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      cnt_q         <= '0;
      ptr_q         <= '0;
      mask_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grants_q      <= grants_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      timeout_q     <= timeout_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      mask_q        <= mask_d;
    end
  end

  assign grants      = grants_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/pci_arbiter_n.md
PCI_ARBITER_N -- requirements
Module: pci_arbiter_n

Interface
REQ-001 SHALL provide parameter NUM_MASTERS, default 5, number of requesters (legal 2..16).
REQ-002 SHALL provide parameter MODE, default 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 SHALL provide parameter PARK_EN, default 1, where 1 parks the bus on PARK_MASTER when idle with no requests.
REQ-004 SHALL provide parameter PARK_MASTER, default 0, index of the parked master.
REQ-005 SHALL provide parameter GNT_TIMEOUT, default 16, idle-bus cycles a granted master may leave FRAME# unasserted (legal 2..255).
REQ-006 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset; requests input NUM_MASTERS, REQ# per master, active-low; frame input 1, FRAME#, active-low; iReady input 1, IRDY#, active-low; grants output NUM_MASTERS, GNT# per master, active-low; owner output OW=max(1,$clog2(NUM_MASTERS)), index of current or last grantee; owner_valid output 1, high while any grant is low; timeout output 1, one-cycle pulse on grant revocation by timeout.
REQ-007 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-008 SHALL register all outputs; the decision at edge k uses requests/frame/iReady sampled at edge k, and the result is visible after edge k.
REQ-009 SHALL define bus idle as frame=1 and iReady=1.
REQ-010 SHALL assert at most one grants bit low in any cycle.
REQ-011 SHALL implement states IDLE, GRANT, BUSY and SWITCH.
REQ-012 In IDLE, SHALL hold all grants high, or only grants[PARK_MASTER] low if PARK_EN=1.
REQ-013 IDLE SHALL go to GRANT(W) when any request is low and the bus is idle; if a different master is parked, it SHALL go through SWITCH first; if W is the parked master, the grant is held without a gap.
REQ-014 In GRANT, the owner grant SHALL stay low and a wait counter SHALL increment each idle-bus cycle.
REQ-015 GRANT SHALL go to BUSY on frame=0.
REQ-016 GRANT SHALL go to SWITCH if the owner's request goes high while the bus is idle.
REQ-017 GRANT SHALL go to SWITCH with timeout=1 when the counter reaches GNT_TIMEOUT.
REQ-018 In BUSY, the owner grant SHALL remain low while no other request is pending.
REQ-019 In BUSY, any other pending request SHALL drive all grants high (preemption); the owner completes its transaction.
REQ-020 BUSY SHALL exit on bus idle: to GRANT(W) if a request is pending, where re-granting a preempted or same owner needs no extra gap; otherwise to IDLE.
REQ-021 SWITCH SHALL last exactly one cycle with all grants high, recompute W, then go to GRANT(W), or IDLE if no request is pending.
REQ-022 In MODE=1, SHALL search from pointer ptr upward with wrap, and set ptr=(owner+1) mod NUM_MASTERS when the owner leaves GRANT/BUSY.
REQ-023 In MODE=0, SHALL pick the highest-index low request.
REQ-024 SHALL mask a master that timed out from the next single arbitration in both modes.
REQ-025 SHALL let a requester win when its request drops at the same edge another request rises; the dropping requester is not eligible.
REQ-026 SHALL clear the wait counter on every GRANT entry and saturate it, never wrapping.
REQ-027 SHALL keep owner at the last grantee in IDLE, or PARK_MASTER when parked.

Reset
REQ-028 rst_n=0 SHALL immediately force grants all-ones, owner_valid=0, timeout=0, owner=0, ptr=0, counter=0, state IDLE, asynchronously and mid-transaction included.
REQ-029 SHALL apply parking, if enabled, at the first rising edge after rst_n deasserts.

Verification
REQ-030 Scenario: N=5, MODE=0, requests=01111, bus idle -> grants=01111 after next edge, owner=4; frame=0 -> BUSY, grant held.
REQ-031 Scenario: MODE=1, requests=00000 held, each master runs one transaction -> grant order 0,1,2,3,4,0, with SWITCH gaps only between idle-bus handovers.
REQ-032 Scenario: master 2 granted, frame held 1 for 16 cycles -> at cycle 16 grants=11111 for one cycle, timeout=1 pulse, next grant to another requester, master 2 skipped once.
REQ-033 Scenario: master 1 in BUSY, requests=10101 (masters 1 and 3) -> grants=11111 while frame=0; on bus idle grants=10111, owner=3.
REQ-034 Scenario: PARK_EN=1, PARK_MASTER=0, no requests -> grants=11110; request master 3 -> 11111 for one cycle, then 10111.
REQ-035 Scenario: rst_n low mid-BUSY -> grants=11111 and owner_valid=0 before the next clk edge; after release, parked grant per REQ-029.
